// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 transaction scheduler: state encoding,
// RTC command bytes and the packed time snapshot type.
package ds1302_pkg;

    localparam logic [2:0] ST_INIT_WR   = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT = 3'd1;
    localparam logic [2:0] ST_TICK      = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT   = 3'd4;
    localparam logic [2:0] ST_PUBLISH   = 3'd5;
    localparam logic [2:0] ST_SET_ISSUE = 3'd6;
    localparam logic [2:0] ST_SET_WAIT  = 3'd7;

    localparam logic [7:0] CMD_WP_WR  = 8'h8E;
    localparam logic [7:0] CMD_SEC_WR = 8'h80;
    localparam logic [7:0] CMD_SEC_RD = 8'h81;

    localparam int unsigned NUM_TIME_REGS = 7;
    localparam int unsigned TICK_W        = 19;

    typedef logic [8*NUM_TIME_REGS-1:0] time_bcd_t;

    // Time registers sit at even offsets from the seconds command.
    function automatic logic [7:0] reg_cmd(input logic [7:0] base, input logic [2:0] idx);
        return base + {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/ds1302_sched.sv
// DS1302 scheduler: clears write-protect, polls the seven time registers
// periodically, services host set-time bursts and selects the bus owner.
module ds1302_sched
    import ds1302_pkg::*;
#(
    parameter int unsigned POLL_DIV = 500000,
    parameter int unsigned TIMEOUT  = 127
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        set_req,
    input  logic [55:0] set_time,
    output logic        set_busy,
    output logic [55:0] time_out,
    output logic        time_valid,
    output logic        err,
    output logic        rd_start,
    output logic [7:0]  rd_cmd,
    input  logic [7:0]  rd_data,
    input  logic        rd_done,
    output logic        wr_start,
    output logic [7:0]  wr_cmd,
    output logic [7:0]  wr_byte,
    input  logic        wr_done,
    output logic        bus_sel
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic [TICK_W-1:0] TICK_END =
        (POLL_DIV == 0)              ? '0 :
        (POLL_DIV > (1 << TICK_W))   ? '1 : TICK_W'(POLL_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_TIME_REGS - 1);

    logic [2:0]        state;
    logic [2:0]        idx;
    logic [TICK_W-1:0] tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    time_bcd_t         shadow;
    time_bcd_t         set_latch;
    logic              init_ok;
    logic [7:0]        set_byte;
    logic              to_expired;

    always_comb begin
        set_byte = '0;
        for (int unsigned i = 0; i < NUM_TIME_REGS; i++) begin
            if (idx == 3'(i)) begin
                set_byte = set_latch[i*8 +: 8];
            end
        end
    end

    assign to_expired = (to_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_INIT_WR;
            idx        <= '0;
            tick_cnt   <= '0;
            to_cnt     <= '0;
            shadow     <= '0;
            set_latch  <= '0;
            init_ok    <= 1'b0;
            time_out   <= '0;
            time_valid <= 1'b0;
            err        <= 1'b0;
            set_busy   <= 1'b0;
            rd_start   <= 1'b0;
            rd_cmd     <= '0;
            wr_start   <= 1'b0;
            wr_cmd     <= '0;
            wr_byte    <= '0;
            bus_sel    <= 1'b1;
        end else begin
            rd_start   <= 1'b0;
            wr_start   <= 1'b0;
            time_valid <= 1'b0;
            err        <= 1'b0;

            // Accepted at any time; the FSM picks it up on its next TICK visit.
            if (set_req && !set_busy) begin
                set_busy  <= 1'b1;
                set_latch <= set_time;
            end

            case (state)
                ST_INIT_WR: begin
                    bus_sel  <= 1'b1;
                    wr_cmd   <= CMD_WP_WR;
                    wr_byte  <= 8'h00;
                    wr_start <= 1'b1;
                    to_cnt   <= '0;
                    state    <= ST_INIT_WAIT;
                end

                ST_INIT_WAIT: begin
                    if (wr_done) begin
                        init_ok <= 1'b1;
                        state   <= ST_TICK;
                    end else if (to_expired) begin
                        err   <= 1'b1;
                        state <= ST_TICK;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_TICK: begin
                    if (set_busy && init_ok) begin
                        idx   <= '0;
                        state <= ST_SET_ISSUE;
                    end else if (tick_cnt >= TICK_END) begin
                        idx   <= '0;
                        state <= init_ok ? ST_RD_ISSUE : ST_INIT_WR;
                    end else if (tick_cnt != '1) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                ST_RD_ISSUE: begin
                    bus_sel  <= 1'b0;
                    rd_cmd   <= reg_cmd(CMD_SEC_RD, idx);
                    rd_start <= 1'b1;
                    to_cnt   <= '0;
                    state    <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (rd_done) begin
                        for (int unsigned i = 0; i < NUM_TIME_REGS; i++) begin
                            if (idx == 3'(i)) begin
                                shadow[i*8 +: 8] <= rd_data;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= ST_PUBLISH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_RD_ISSUE;
                        end
                    end else if (to_expired) begin
                        err   <= 1'b1;
                        state <= ST_TICK;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_PUBLISH: begin
                    time_out   <= shadow;
                    time_valid <= 1'b1;
                    state      <= ST_TICK;
                end

                ST_SET_ISSUE: begin
                    bus_sel  <= 1'b1;
                    wr_cmd   <= reg_cmd(CMD_SEC_WR, idx);
                    wr_byte  <= set_byte;
                    wr_start <= 1'b1;
                    to_cnt   <= '0;
                    state    <= ST_SET_WAIT;
                end

                ST_SET_WAIT: begin
                    if (wr_done) begin
                        if (idx == LAST_IDX) begin
                            set_busy <= 1'b0;
                            state    <= ST_TICK;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_SET_ISSUE;
                        end
                    end else if (to_expired) begin
                        err      <= 1'b1;
                        set_busy <= 1'b0;
                        state    <= ST_TICK;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: state <= ST_INIT_WR;
            endcase

            // Holding the counter at zero outside TICK gives every return to
            // TICK (publish, set end, timeout) a fresh full poll period.
            if (state != ST_TICK) begin
                tick_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ds1302_sched.sv
// Scoreboard bench for ds1302_sched with behavioural read/write engines.
module tb_ds1302_sched;

    localparam int unsigned POLL_DIV = 200;
    localparam int unsigned TIMEOUT  = 127;
    localparam int unsigned ENG_LAT  = 47;
    localparam int unsigned BUDGET   = 3000;

    localparam logic [55:0] T1 = 56'h24071231235930;
    localparam logic [55:0] S1 = 56'h25030615104500;
    localparam logic [55:0] S2 = 56'h99999999999999;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_req = 1'b0;
    logic [55:0] set_time = '0;
    logic        set_busy;
    logic [55:0] time_out;
    logic        time_valid;
    logic        err;
    logic        rd_start;
    logic [7:0]  rd_cmd;
    logic [7:0]  rd_data = '0;
    logic        rd_done = 1'b0;
    logic        wr_start;
    logic [7:0]  wr_cmd;
    logic [7:0]  wr_byte;
    logic        wr_done = 1'b0;
    logic        bus_sel;

    ds1302_sched #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .rst(rst), .set_req(set_req), .set_time(set_time),
        .set_busy(set_busy), .time_out(time_out), .time_valid(time_valid), .err(err),
        .rd_start(rd_start), .rd_cmd(rd_cmd), .rd_data(rd_data), .rd_done(rd_done),
        .wr_start(wr_start), .wr_cmd(wr_cmd), .wr_byte(wr_byte), .wr_done(wr_done),
        .bus_sel(bus_sel)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_rd[$];
    logic [15:0] exp_wr[$];
    logic [55:0] exp_tv[$];
    int unsigned exp_err[$];
    int n_rd = 0, n_wr = 0, n_tv = 0, n_err = 0;
    int unsigned last_rd_cyc = 0;
    bit drop_en = 1'b0;
    logic [7:0] drop_cmd = 8'h85;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    function automatic logic [7:0] rd_val(input logic [7:0] c);
        case (c)
            8'h81: return 8'h30;
            8'h83: return 8'h59;
            8'h85: return 8'h23;
            8'h87: return 8'h31;
            8'h89: return 8'h12;
            8'h8B: return 8'h07;
            8'h8D: return 8'h24;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic push_poll(input bit with_tv);
        for (int i = 0; i < 7; i++) exp_rd.push_back(8'h81 + 8'(2 * i));
        if (with_tv) exp_tv.push_back(T1);
    endtask

    task automatic push_set(input logic [55:0] t);
        logic [55:0] v;
        v = t;
        for (int i = 0; i < 7; i++) exp_wr.push_back({8'h80 + 8'(2 * i), v[i*8 +: 8]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_time_out"}, 64'(time_out), 64'h0);
        check({tag, "_time_valid"}, 64'(time_valid), 64'h0);
        check({tag, "_err"}, 64'(err), 64'h0);
        check({tag, "_set_busy"}, 64'(set_busy), 64'h0);
        check({tag, "_bus_sel"}, 64'(bus_sel), 64'h1);
        check({tag, "_rd_start"}, 64'(rd_start), 64'h0);
        check({tag, "_wr_start"}, 64'(wr_start), 64'h0);
        check({tag, "_rd_cmd"}, 64'(rd_cmd), 64'h0);
        check({tag, "_wr_cmd"}, 64'(wr_cmd), 64'h0);
        check({tag, "_wr_byte"}, 64'(wr_byte), 64'h0);
    endtask

    // sel: 0 rd starts, 1 wr starts, 2 time_valid, 3 err, other: set_busy low
    task automatic wait_until(input int sel, input int target, input string name);
        int unsigned n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < BUDGET) begin
            @(negedge sys_clk);
            #1;
            n++;
            case (sel)
                0: ok = (n_rd >= target);
                1: ok = (n_wr >= target);
                2: ok = (n_tv >= target);
                3: ok = (n_err >= target);
                default: ok = (set_busy == 1'b0);
            endcase
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=timeout required=event within %0d cycles", name, BUDGET);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial forever begin
        logic [7:0]  e8;
        logic [15:0] e16;
        logic [55:0] e56;
        int unsigned ed;
        @(negedge sys_clk);
        if (rd_start) begin
            n_rd++;
            last_rd_cyc = cyc;
            if (exp_rd.size() == 0) unexpected("rd_start_unexpected", 64'(rd_cmd));
            else begin
                e8 = exp_rd.pop_front();
                check("rd_cmd", 64'(rd_cmd), 64'(e8));
                check("rd_bus_sel", 64'(bus_sel), 64'h0);
            end
        end
        if (wr_start) begin
            n_wr++;
            if (exp_wr.size() == 0) unexpected("wr_start_unexpected", 64'({wr_cmd, wr_byte}));
            else begin
                e16 = exp_wr.pop_front();
                check("wr_cmd_byte", 64'({wr_cmd, wr_byte}), 64'(e16));
                check("wr_bus_sel", 64'(bus_sel), 64'h1);
            end
        end
        if (time_valid) begin
            n_tv++;
            if (exp_tv.size() == 0) unexpected("time_valid_unexpected", 64'(time_out));
            else begin
                e56 = exp_tv.pop_front();
                check("time_out", 64'(time_out), 64'(e56));
            end
        end
        if (err) begin
            n_err++;
            if (exp_err.size() == 0) unexpected("err_unexpected", 64'(cyc));
            else begin
                ed = exp_err.pop_front();
                check("err_latency", 64'(cyc - last_rd_cyc), 64'(ed));
            end
        end
    end

    // Behavioural read engine; a dropped command never returns done.
    initial forever begin
        logic [7:0] c;
        bit ab;
        @(negedge sys_clk);
        if (rst && rd_start) begin
            c = rd_cmd;
            ab = 1'b0;
            for (int i = 1; i < int'(ENG_LAT); i++) begin
                @(negedge sys_clk);
                if (!rst) ab = 1'b1;
            end
            if (!ab && !(drop_en && c == drop_cmd)) begin
                check("rd_cmd_hold", 64'(rd_cmd), 64'(c));
                rd_data = rd_val(c);
                rd_done = 1'b1;
                @(negedge sys_clk);
                rd_done = 1'b0;
            end
        end
    end

    // Behavioural write engine.
    initial forever begin
        logic [15:0] c;
        bit ab;
        @(negedge sys_clk);
        if (rst && wr_start) begin
            c = {wr_cmd, wr_byte};
            ab = 1'b0;
            for (int i = 1; i < int'(ENG_LAT); i++) begin
                @(negedge sys_clk);
                if (!rst) ab = 1'b1;
            end
            if (!ab) begin
                check("wr_hold", 64'({wr_cmd, wr_byte}), 64'(c));
                wr_done = 1'b1;
                @(negedge sys_clk);
                wr_done = 1'b0;
            end
        end
    end

    initial begin
        #12;
        check_reset_outputs("reset");

        // Init write, then the first poll.
        exp_wr.push_back(16'h8E00);
        push_poll(1'b1);
        @(negedge sys_clk);
        rst = 1'b1;
        wait_until(2, 1, "poll1_time_valid");

        // Set request during the 4th read of the second poll.
        push_poll(1'b1);
        push_set(S1);
        wait_until(0, 11, "poll2_4th_read");
        set_time = S1;
        set_req = 1'b1;
        @(posedge sys_clk);
        #1;
        set_req = 1'b0;
        check("set_busy_rise", 64'(set_busy), 64'h1);
        repeat (3) @(negedge sys_clk);
        set_time = S2;
        set_req = 1'b1;
        @(posedge sys_clk);
        #1;
        set_req = 1'b0;
        check("set_busy_still_high", 64'(set_busy), 64'h1);
        wait_until(4, 0, "set_busy_fall");
        check("set_write_count", 64'(n_wr), 64'd8);
        check("set_writes_left", 64'(exp_wr.size()), 64'd0);
        check("poll2_published", 64'(n_tv), 64'd2);
        check("time_after_set", 64'(time_out), 64'(T1));

        // Third read of the next poll never completes.
        drop_en = 1'b1;
        exp_rd.push_back(8'h81);
        exp_rd.push_back(8'h83);
        exp_rd.push_back(8'h85);
        exp_err.push_back(TIMEOUT);
        wait_until(3, 1, "poll_timeout_err");
        drop_en = 1'b0;
        check("timeout_reads_left", 64'(exp_rd.size()), 64'd0);
        check("timeout_time_held", 64'(time_out), 64'(T1));
        check("timeout_no_valid", 64'(n_tv), 64'd2);

        // Next poll runs normally.
        push_poll(1'b1);
        wait_until(2, 3, "poll4_time_valid");

        // Reset during RD_WAIT of the second read.
        exp_rd.push_back(8'h81);
        exp_rd.push_back(8'h83);
        wait_until(0, 26, "poll5_2nd_read");
        repeat (5) @(negedge sys_clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge sys_clk);
        exp_wr.push_back(16'h8E00);
        rst = 1'b1;
        wait_until(1, 9, "reinit_write");
        repeat (60) @(negedge sys_clk);

        check("final_rd_queue", 64'(exp_rd.size()), 64'd0);
        check("final_wr_queue", 64'(exp_wr.size()), 64'd0);
        check("final_tv_queue", 64'(exp_tv.size()), 64'd0);
        check("final_err_queue", 64'(exp_err.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
